// File: rtl/spi_mem_arbiter.sv
// ============================================================================
// Module      : spi_mem_arbiter
// Description : Shares one SPI flash reader between instruction fetch (IF)
//               and data load (D). Round-robin arbitration, one outstanding
//               transaction, level start/done handshake to the reader,
//               response routing, and a watchdog that aborts a hung read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_mem_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              mem_start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              mem_done,
    output logic              busy
);

    // Counter is at least one bit wide so the disabled build still elaborates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               owner_is_d_q, owner_is_d_d;   // owner of current transaction
    logic               last_is_d_q, last_is_d_d;     // last granted port (0 = IF)
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               if_gnt_q, if_gnt_d;
    logic               d_gnt_q, d_gnt_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               mem_start_q, mem_start_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               busy_q, busy_d;

    logic               grant_to_d;
    logic               wdog_expire;

    // Watchdog expiry decode; tied off when the watchdog is disabled.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog_on
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            assign wdog_expire = (cnt_q == CNT_LAST);
        end else begin : g_wdog_off
            assign wdog_expire = 1'b0;
        end
    endgenerate

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        owner_is_d_d = owner_is_d_q;
        last_is_d_d  = last_is_d_q;
        cnt_d        = cnt_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        mem_start_d  = mem_start_q;
        mem_addr_d   = mem_addr_q;
        grant_to_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    // D wins when alone, or on a tie when IF went last.
                    grant_to_d   = d_req && (!if_req || !last_is_d_q);
                    state_d      = ST_BUSY;
                    owner_is_d_d = grant_to_d;
                    last_is_d_d  = grant_to_d;
                    if_gnt_d     = !grant_to_d;
                    d_gnt_d      = grant_to_d;
                    mem_start_d  = 1'b1;
                    mem_addr_d   = grant_to_d ? d_addr : if_addr;
                    cnt_d        = '0;
                end
            end
            ST_BUSY: begin
                if (mem_done) begin
                    // A done arriving on the expiry cycle still counts as success.
                    rsp_data_d  = mem_data;
                    rsp_err_d   = 1'b0;
                    if_rvalid_d = !owner_is_d_q;
                    d_rvalid_d  = owner_is_d_q;
                    mem_start_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else if (wdog_expire) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    if_rvalid_d = !owner_is_d_q;
                    d_rvalid_d  = owner_is_d_q;
                    mem_start_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Do not re-arm the reader until it has dropped done.
                if (!mem_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_start_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_is_d_q <= 1'b0;
            last_is_d_q  <= 1'b0;
            cnt_q        <= '0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            mem_start_q  <= 1'b0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_is_d_q <= owner_is_d_d;
            last_is_d_q  <= last_is_d_d;
            cnt_q        <= cnt_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            mem_start_q  <= mem_start_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mem_start = mem_start_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_mem_arbiter.sv
// ============================================================================
// Module      : tb_spi_mem_arbiter
// Description : Directed self-checking bench for spi_mem_arbiter. A default
//               instance and a TIMEOUT_CYCLES=16 instance share all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, mem_done;
    logic [23:0] if_addr, d_addr;
    logic [31:0] mem_data;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, rsp_err, mem_start, busy;
    logic [31:0] rsp_data;
    logic [23:0] mem_addr;

    logic        wd_if_gnt, wd_if_rvalid, wd_d_gnt, wd_d_rvalid, wd_rsp_err, wd_mem_start, wd_busy;
    logic [31:0] wd_rsp_data;
    logic [23:0] wd_mem_addr;

    int vectors    = 0;
    int miscompares = 0;

    spi_mem_arbiter #(.ADDR_W(24), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_start(mem_start), .mem_addr(mem_addr), .mem_data(mem_data), .mem_done(mem_done),
        .busy(busy)
    );

    spi_mem_arbiter #(.ADDR_W(24), .TIMEOUT_CYCLES(16)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(wd_if_gnt), .if_rvalid(wd_if_rvalid),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(wd_d_gnt), .d_rvalid(wd_d_rvalid),
        .rsp_data(wd_rsp_data), .rsp_err(wd_rsp_err),
        .mem_start(wd_mem_start), .mem_addr(wd_mem_addr), .mem_data(mem_data), .mem_done(mem_done),
        .busy(wd_busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both rvalids must never be high together, and never gnt+rvalid for one port.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            vectors++;
            if ((if_rvalid && d_rvalid) || (if_rvalid && if_gnt) || (d_rvalid && d_gnt)) begin
                miscompares++;
                $display("FAIL excl: if_gnt=%b if_rvalid=%b d_gnt=%b d_rvalid=%b required no overlap",
                         if_gnt, if_rvalid, d_gnt, d_rvalid);
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        if_req = 1'b0; d_req = 1'b0; mem_done = 1'b0; mem_data = '0;
        rst_n = 1'b1;
    endtask

    // One transaction on the default instance: wait for grant, check owner and
    // address, let the reader finish after lat cycles, check the response.
    task automatic run_txn(input bit exp_d, input logic [23:0] exp_addr,
                           input logic [31:0] data, input int lat, input bit drop_req,
                           input bit keep_done);
        int  n;
        bit  held;
        n = 0;
        step();
        while (!(if_gnt || d_gnt) && n < 10) begin
            step();
            n++;
        end
        vectors++;
        if ({d_gnt, if_gnt} !== (exp_d ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL txn_gnt: {d_gnt,if_gnt}=%b required %b", {d_gnt, if_gnt}, exp_d ? 2'b10 : 2'b01);
        end
        vectors++;
        if (mem_addr !== exp_addr || mem_start !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL txn_start: mem_addr=%h mem_start=%b busy=%b required %h 1 1",
                     mem_addr, mem_start, busy, exp_addr);
        end
        if (drop_req) begin
            if (exp_d) d_req = 1'b0; else if_req = 1'b0;
        end
        held = 1'b1;
        repeat (lat) begin
            step();
            if (mem_start !== 1'b1 || mem_addr !== exp_addr || if_rvalid || d_rvalid || if_gnt || d_gnt)
                held = 1'b0;
        end
        vectors++;
        if (!held) begin
            miscompares++;
            $display("FAIL txn_hold: mem_start/mem_addr not held or spurious pulse, required start=1 addr=%h", exp_addr);
        end
        mem_done = 1'b1;
        mem_data = data;
        step();
        vectors++;
        if ({d_rvalid, if_rvalid} !== (exp_d ? 2'b10 : 2'b01) || rsp_data !== data ||
            rsp_err !== 1'b0 || mem_start !== 1'b0) begin
            miscompares++;
            $display("FAIL txn_rsp: rv=%b data=%h err=%b start=%b required rv=%b data=%h err=0 start=0",
                     {d_rvalid, if_rvalid}, rsp_data, rsp_err, mem_start,
                     exp_d ? 2'b10 : 2'b01, data);
        end
        if (!keep_done) mem_done = 1'b0;
    endtask

    task automatic test_reset();
        if_req = 1'b1; d_req = 1'b1; mem_done = 1'b1;
        if_addr = 24'hABCDEF; d_addr = 24'h123456; mem_data = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if ({if_gnt, if_rvalid, d_gnt, d_rvalid, rsp_err, mem_start, busy} !== 7'b0 ||
            rsp_data !== 32'h0 || mem_addr !== 24'h0) begin
            miscompares++;
            $display("FAIL reset: gnt=%b%b rv=%b%b err=%b start=%b busy=%b data=%h addr=%h required all 0",
                     if_gnt, d_gnt, if_rvalid, d_rvalid, rsp_err, mem_start, busy, rsp_data, mem_addr);
        end
        if_req = 1'b0; d_req = 1'b0; mem_done = 1'b0; mem_data = '0;
        rst_n = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b gnt=%b%b required 0", busy, if_gnt, d_gnt);
        end
    endtask

    task automatic test_single_if();
        if_addr = 24'h000100;
        if_req  = 1'b1;
        run_txn(1'b0, 24'h000100, 32'hDEADBEEF, 40, 1'b1, 1'b0);
        step();
        vectors++;
        if (busy !== 1'b0 || if_rvalid !== 1'b0 || rsp_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_after: busy=%b if_rvalid=%b data=%h required 0 0 deadbeef",
                     busy, if_rvalid, rsp_data);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        if_addr = 24'h0000A0; d_addr = 24'h0000D0;
        if_req = 1'b1; d_req = 1'b1;
        run_txn(1'b1, 24'h0000D0, 32'h1111_0001, 3, 1'b1, 1'b0);
        run_txn(1'b0, 24'h0000A0, 32'h2222_0002, 3, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_fairness();
        apply_reset();
        if_addr = 24'h010000; d_addr = 24'h020000;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_txn((i % 2) == 0, ((i % 2) == 0) ? 24'h020000 : 24'h010000,
                    32'h3000_0000 + i, 2, 1'b0, 1'b0);
        end
        if_req = 1'b0; d_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        bool_quiet: begin end
        apply_reset();
        // Done on the expiry cycle: normal response wins.
        if_addr = 24'h000400;
        if_req  = 1'b1;
        step();
        vectors++;
        if (wd_if_gnt !== 1'b1 || wd_mem_addr !== 24'h000400) begin
            miscompares++;
            $display("FAIL wd_gnt1: if_gnt=%b addr=%h required 1 000400", wd_if_gnt, wd_mem_addr);
        end
        if_req = 1'b0;
        repeat (15) step();
        mem_done = 1'b1;
        mem_data = 32'hCAFEF00D;
        step();
        vectors++;
        if (wd_if_rvalid !== 1'b1 || wd_rsp_err !== 1'b0 || wd_rsp_data !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL wd_done_on_expiry: rvalid=%b err=%b data=%h required 1 0 cafef00d",
                     wd_if_rvalid, wd_rsp_err, wd_rsp_data);
        end
        mem_done = 1'b0;
        step();
        // Reader never answers: abort exactly 16 cycles after grant.
        d_addr = 24'h000500;
        d_req  = 1'b1;
        step();
        vectors++;
        if (wd_d_gnt !== 1'b1 || wd_mem_addr !== 24'h000500) begin
            miscompares++;
            $display("FAIL wd_gnt2: d_gnt=%b addr=%h required 1 000500", wd_d_gnt, wd_mem_addr);
        end
        d_req = 1'b0;
        begin
            bit early;
            early = 1'b0;
            repeat (15) begin
                step();
                if (wd_d_rvalid || wd_if_rvalid || wd_mem_start !== 1'b1) early = 1'b1;
            end
            vectors++;
            if (early) begin
                miscompares++;
                $display("FAIL wd_early: response or start drop before 16 cycles, required none");
            end
        end
        step();
        vectors++;
        if (wd_d_rvalid !== 1'b1 || wd_rsp_err !== 1'b1 || wd_rsp_data !== 32'h0 || wd_mem_start !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_abort: rvalid=%b err=%b data=%h start=%b required 1 1 0 0",
                     wd_d_rvalid, wd_rsp_err, wd_rsp_data, wd_mem_start);
        end
        step();
        vectors++;
        if (wd_busy !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_release: wd_busy=%b busy=%b required 0 1", wd_busy, busy);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit quiet;
        apply_reset();
        if_addr = 24'h000600;
        if_req  = 1'b1;
        step();
        if_req = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if ({if_gnt, if_rvalid, d_gnt, d_rvalid, rsp_err, mem_start, busy} !== 7'b0 || mem_addr !== 24'h0) begin
            miscompares++;
            $display("FAIL mid_reset: gnt=%b%b rv=%b%b start=%b busy=%b addr=%h required all 0",
                     if_gnt, d_gnt, if_rvalid, d_rvalid, mem_start, busy, mem_addr);
        end
        quiet = 1'b1;
        repeat (3) begin
            step();
            if (if_rvalid || d_rvalid || mem_start || busy) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL mid_reset_quiet: activity after abort, required none");
        end
        if_addr = 24'h000700;
        if_req  = 1'b1;
        run_txn(1'b0, 24'h000700, 32'h0BAD_F00D, 4, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_stuck_done();
        bit ok;
        apply_reset();
        if_addr = 24'h000800;
        if_req  = 1'b1;
        run_txn(1'b0, 24'h000800, 32'h5555_AAAA, 2, 1'b1, 1'b1);
        if_addr = 24'h000900;
        if_req  = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            step();
            if (busy !== 1'b1 || if_gnt || d_gnt || mem_start) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stuck_hold: busy dropped or grant issued while done stuck, required busy=1 no gnt");
        end
        mem_done = 1'b0;
        step();
        vectors++;
        if (if_gnt !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_idle: if_gnt=%b busy=%b required 0 0", if_gnt, busy);
        end
        step();
        vectors++;
        if (if_gnt !== 1'b1 || mem_addr !== 24'h000900 || mem_start !== 1'b1) begin
            miscompares++;
            $display("FAIL stuck_regrant: if_gnt=%b addr=%h start=%b required 1 000900 1",
                     if_gnt, mem_addr, mem_start);
        end
        if_req = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; mem_done = 1'b0;
        if_addr = '0; d_addr = '0; mem_data = '0;
        test_reset();
        test_single_if();
        test_tie();
        test_fairness();
        test_timeout();
        test_reset_mid_busy();
        test_stuck_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
